fetch_if_id_stage: RTL

Fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline. It owns the PC, sends it to instruction memory, and latches the returned instruction and PC+4 into the IF/ID register. It is the direct consumer of the hazard unit's 2-bit flush/stall code and of the decode-stage branch redirect, since branches resolve in Decode. It also keeps stall and flush event counters for debug and performance readout.

---
 rtl/fetch_if_id_stage.sv | 109 ++++++++++
 1 files changed

// File: rtl/fetch_if_id_stage.sv
// Fetch stage and IF/ID pipeline register for the 5-stage MIPS pipeline.
// It owns the PC, applies hazard holds and decode-stage redirects, and counts stall/flush events.
module fetch_if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instruction,
    input  logic [1:0]  FlushSignal,
    input  logic        ID_BranchTaken,
    input  logic [31:0] ID_BranchTarget,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount
);

    typedef enum logic [1:0] {
        PH_RUN     = 2'd0,
        PH_STALLED = 2'd1,
        PH_SQUASH  = 2'd2
    } phase_t;

    logic [31:0] r_pc;
    logic [31:0] r_if_id_instr;
    logic [31:0] r_if_id_pcplus4;
    logic        r_if_id_valid;
    logic [31:0] r_stall_count;
    logic [31:0] r_flush_count;
    phase_t      r_phase;
    phase_t      w_phase_next;

    logic        w_hold;
    logic        w_redirect;
    logic [31:0] w_pc_plus4;
    logic        w_in_run;
    logic        w_in_squash;

    // 2'b10 is a reserved code and deliberately falls through to advance.
    assign w_hold     = (FlushSignal == 2'b01) || (FlushSignal == 2'b11);
    assign w_redirect = !w_hold && ID_BranchTaken;
    assign w_pc_plus4 = r_pc + 32'd4;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pc            <= RESET_PC;
            r_if_id_instr   <= NOP_WORD;
            r_if_id_pcplus4 <= RESET_PC + 32'd4;
            r_if_id_valid   <= 1'b0;
            r_stall_count   <= 32'd0;
            r_flush_count   <= 32'd0;
        end else if (w_hold) begin
            r_stall_count   <= r_stall_count + 32'd1;
        end else if (w_redirect) begin
            r_pc            <= ID_BranchTarget;
            r_if_id_instr   <= NOP_WORD;
            r_if_id_pcplus4 <= w_pc_plus4;
            r_if_id_valid   <= 1'b0;
            r_flush_count   <= r_flush_count + 32'd1;
        end else begin
            r_pc            <= w_pc_plus4;
            r_if_id_instr   <= Instruction;
            r_if_id_pcplus4 <= w_pc_plus4;
            r_if_id_valid   <= 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_phase <= PH_SQUASH;
        end else begin
            r_phase <= w_phase_next;
        end
    end

    always_comb begin
        w_phase_next = PH_RUN;
        if (w_hold) begin
            w_phase_next = PH_STALLED;
        end else if (w_redirect) begin
            w_phase_next = PH_SQUASH;
        end
    end

    always_comb begin
        w_in_run    = 1'b0;
        w_in_squash = 1'b0;
        case (r_phase)
            PH_RUN:    w_in_run    = 1'b1;
            PH_SQUASH: w_in_squash = 1'b1;
            default:   ;
        endcase
    end

    // The phase tracks whether IF/ID currently holds a real instruction or a bubble.
    a_run_valid: assert property (@(posedge Clk) disable iff (Reset) w_in_run |-> r_if_id_valid);
    a_squash_bubble: assert property (@(posedge Clk) disable iff (Reset) w_in_squash |-> !r_if_id_valid);

    assign PC                = r_pc;
    assign IF_ID_Instruction = r_if_id_instr;
    assign IF_ID_PCPlus4     = r_if_id_pcplus4;
    assign IF_ID_Valid       = r_if_id_valid;
    assign StallCount        = r_stall_count;
    assign FlushCount        = r_flush_count;

endmodule
